// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for an area-reduced RV32I core.
//
// The core shares one ALU and one unified instruction/data memory port.
// This FSM steps each instruction through fetch, decode, execute, memory
// and writeback phases. It inserts memory wait-states through the
// mem_ready_i handshake, counts retired instructions, and traps on
// unsupported opcodes.
//
// Ports:
//   clk_i, rst_i         clock; synchronous active-high reset
//   op_i, funct3_i       instruction fields (only funct3_i[0] is used)
//   zero_i               ALU zero flag, used for branch resolution
//   mem_ready_i          the memory access completes this cycle
//   mem_req_o            memory request
//   mem_write_o          memory write strobe
//   adr_src_o            memory address select: 0 = PC, 1 = ALUOut
//   ir_write_o           load the instruction register and OldPC
//   pc_write_o           PC enable
//   reg_write_o          register file write enable
//   alu_src_a_o          ALU operand A: 00 = PC, 01 = OldPC, 10 = rs1
//   alu_src_b_o          ALU operand B: 00 = rs2, 01 = imm, 10 = constant 4
//   alu_op_o             00 = add, 01 = subtract/compare, 10 = funct-decoded
//   result_src_o         00 = ALUOut, 01 = read data, 10 = ALU result
//   imm_src_o            immediate type: I = 00, S = 01, B = 10, J = 11
//   state_o              current state encoding, for debug
//   illegal_o            high while in TRAP
//   instret_o            retired-instruction count
module multicycle_controller (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_write_o,
  output logic        adr_src_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        reg_write_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  result_src_o,
  output logic [1:0]  imm_src_o,
  output logic [3:0]  state_o,
  output logic        illegal_o,
  output logic [31:0] instret_o
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;

  // Only funct3[0] selects beq/bne. The upper bits are not used.
  logic unused_funct3;
  assign unused_funct3 = ^funct3_i[2:1];

  // Next-state and retirement logic.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        case (op_i)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        state_d = (op_i == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        if (mem_ready_i) state_d = StMemWb;
      end
      StMemWrite: begin
        if (mem_ready_i) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR, StExecI, StJal: begin
        state_d = StAluWb;
      end
      StMemWb, StAluWb, StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap: begin
        state_d = StTrap;
      end
      // Encodings 12-15 are unreachable. Recover to FETCH.
      default: begin
        state_d = StFetch;
      end
    endcase
    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Immediate type depends only on the opcode, so it is valid in every state.
  always_comb begin
    case (op_i)
      OpStore:  imm_src_o = 2'b01;
      OpBranch: imm_src_o = 2'b10;
      OpJal:    imm_src_o = 2'b11;
      default:  imm_src_o = 2'b00;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    result_src_o = 2'b00;
    illegal_o    = 1'b0;
    case (state_q)
      StFetch: begin
        // PC + 4 is computed while the instruction is read. Both are
        // committed only on the cycle the memory responds.
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      StDecode: begin
        // OldPC + imm is the branch/jump target. It is latched into ALUOut.
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
      end
      StMemAdr: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
      end
      StMemRead: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
      end
      StMemWrite: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
      end
      StMemWb: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
      end
      StExecR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
      end
      StExecI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
      end
      StAluWb: begin
        reg_write_o = 1'b1;
      end
      StBranch: begin
        // funct3[0] selects bne. It inverts the sense of the zero flag.
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        pc_write_o  = zero_i ^ funct3_i[0];
      end
      StJal: begin
        // OldPC + 4 is the link value. The target is already in ALUOut.
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
      end
      StTrap: begin
        illegal_o = 1'b1;
      end
      default: begin
      end
    endcase
    // Reset suppresses every write in the same cycle, including mid-wait.
    if (rst_i) begin
      mem_req_o   = 1'b0;
      mem_write_o = 1'b0;
      ir_write_o  = 1'b0;
      pc_write_o  = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
    end
  end

  assign state_o   = state_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic        clk;
  logic        rst_i;
  logic [6:0]  op_i;
  logic [2:0]  funct3_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        mem_req_o;
  logic        mem_write_o;
  logic        adr_src_o;
  logic        ir_write_o;
  logic        pc_write_o;
  logic        reg_write_o;
  logic [1:0]  alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [1:0]  alu_op_o;
  logic [1:0]  result_src_o;
  logic [1:0]  imm_src_o;
  logic [3:0]  state_o;
  logic        illegal_o;
  logic [31:0] instret_o;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;
  logic [31:0] exp_instret = 32'd0;

  multicycle_controller dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .op_i         (op_i),
    .funct3_i     (funct3_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_write_o  (mem_write_o),
    .adr_src_o    (adr_src_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .reg_write_o  (reg_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .result_src_o (result_src_o),
    .imm_src_o    (imm_src_o),
    .state_o      (state_o),
    .illegal_o    (illegal_o),
    .instret_o    (instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge. Stimulus and checks happen in the high phase.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, state_o}, {28'd0, exp});
  endtask

  // Runs one branch from FETCH with zero wait-states. It checks the state
  // path, the pc_write decision and the retire count.
  task automatic branch_case(input logic [2:0] f3, input logic z, input logic exp_pw);
    op_i = 7'b1100011; funct3_i = f3; zero_i = z; mem_ready_i = 1'b1;
    #1;
    expect_state("br_fetch", 4'd0);
    check("br_imm", {30'd0, imm_src_o}, 32'd2);
    step();
    expect_state("br_decode", 4'd1);
    step();
    expect_state("br_state", 4'd9);
    check("br_pc_write", {31'd0, pc_write_o}, {31'd0, exp_pw});
    check("br_alu_op", {30'd0, alu_op_o}, 32'd1);
    step();
    exp_instret = exp_instret + 32'd1;
    expect_state("br_done", 4'd0);
    check("br_instret", instret_o, exp_instret);
  endtask

  initial begin
    logic [6:0] imm_ops [5];
    logic [1:0] imm_exp [5];
    int wr_cycles;
    imm_ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110011};
    imm_exp = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

    rst_i = 1'b1; op_i = 7'b0110011; funct3_i = 3'b000; zero_i = 1'b0; mem_ready_i = 1'b1;

    // Reset held for two cycles.
    step();
    step();
    expect_state("rst_state", 4'd0);
    check("rst_instret", instret_o, 32'd0);
    check("rst_enables", {27'd0, mem_req_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o},
          32'd0);
    check("rst_illegal", {31'd0, illegal_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    check("rel_ir_write", {31'd0, ir_write_o}, 32'd1);
    check("rel_pc_write", {31'd0, pc_write_o}, 32'd1);
    check("rel_fetch_ctl", {25'd0, mem_req_o, adr_src_o, alu_src_b_o, result_src_o},
          {25'd0, 1'b1, 1'b0, 2'b10, 2'b10});

    // R-type: 0, 1, 6, 8, 0.
    op_i = 7'b0110011;
    check("r_rw0", {31'd0, reg_write_o}, 32'd0);
    step();
    expect_state("r_s1", 4'd1);
    check("r_decode_src", {28'd0, alu_src_a_o, alu_src_b_o}, {28'd0, 2'b01, 2'b01});
    check("r_rw1", {31'd0, reg_write_o}, 32'd0);
    step();
    expect_state("r_s6", 4'd6);
    check("r_exec_ctl", {26'd0, alu_src_a_o, alu_src_b_o, alu_op_o}, {26'd0, 6'b10_00_10});
    check("r_rw6", {31'd0, reg_write_o}, 32'd0);
    step();
    expect_state("r_s8", 4'd8);
    check("r_rw8", {31'd0, reg_write_o}, 32'd1);
    check("r_result_src", {30'd0, result_src_o}, 32'd0);
    step();
    exp_instret = exp_instret + 32'd1;
    expect_state("r_done", 4'd0);
    check("r_instret", instret_o, exp_instret);

    // Load with two wait-states in MEMREAD.
    op_i = 7'b0000011;
    step();
    expect_state("ld_s1", 4'd1);
    step();
    expect_state("ld_s2", 4'd2);
    check("ld_adr_ctl", {26'd0, alu_src_a_o, alu_src_b_o, alu_op_o}, {26'd0, 6'b10_01_00});
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) mem_ready_i = 1'b1;
      #1;
      expect_state("ld_s3", 4'd3);
      check("ld_memreq", {30'd0, mem_req_o, adr_src_o}, 32'd3);
      check("ld_no_write", {31'd0, mem_write_o}, 32'd0);
    end
    step();
    expect_state("ld_s4", 4'd4);
    check("ld_result_src", {30'd0, result_src_o}, 32'd1);
    check("ld_rw", {31'd0, reg_write_o}, 32'd1);
    step();
    exp_instret = exp_instret + 32'd1;
    expect_state("ld_done", 4'd0);
    check("ld_instret", instret_o, exp_instret);

    // Branches: beq taken and not taken, then bne.
    branch_case(3'b000, 1'b1, 1'b1);
    branch_case(3'b000, 1'b0, 1'b0);
    branch_case(3'b001, 1'b1, 1'b0);
    branch_case(3'b001, 1'b0, 1'b1);

    // I-type ALU: 0, 1, 7, 8, 0.
    op_i = 7'b0010011;
    step();
    step();
    expect_state("i_s7", 4'd7);
    check("i_exec_ctl", {26'd0, alu_src_a_o, alu_src_b_o, alu_op_o}, {26'd0, 6'b10_01_10});
    step();
    expect_state("i_s8", 4'd8);
    step();
    exp_instret = exp_instret + 32'd1;
    check("i_instret", instret_o, exp_instret);

    // JAL: 0, 1, 10, 8, 0.
    op_i = 7'b1101111;
    step();
    step();
    expect_state("jal_s10", 4'd10);
    check("jal_ctl", {26'd0, alu_src_a_o, alu_src_b_o, alu_op_o}, {26'd0, 6'b01_10_00});
    check("jal_pc_write", {31'd0, pc_write_o}, 32'd1);
    step();
    expect_state("jal_s8", 4'd8);
    step();
    exp_instret = exp_instret + 32'd1;
    check("jal_instret", instret_o, exp_instret);

    // Store with three wait-states: mem_write_o is held for four cycles.
    op_i = 7'b0100011;
    step();
    step();
    expect_state("st_s2", 4'd2);
    mem_ready_i = 1'b0;
    wr_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) mem_ready_i = 1'b1;
      #1;
      expect_state("st_s5", 4'd5);
      check("st_req_adr", {30'd0, mem_req_o, adr_src_o}, 32'd3);
      if (mem_write_o === 1'b1) wr_cycles++;
      if (i < 3) check("st_no_retire", instret_o, exp_instret);
    end
    check("st_write_cycles", wr_cycles, 32'd4);
    step();
    exp_instret = exp_instret + 32'd1;
    expect_state("st_done", 4'd0);
    check("st_instret", instret_o, exp_instret);

    // Wrap: preload the counter with all ones during a non-retiring edge.
    op_i = 7'b0110011;
    step();
    expect_state("wr_s1", 4'd1);
    force dut.instret_d = 32'hFFFF_FFFF;
    step();
    release dut.instret_d;
    #1;
    check("wr_preload", instret_o, 32'hFFFF_FFFF);
    step();
    step();
    exp_instret = 32'd0;
    expect_state("wr_done", 4'd0);
    check("wr_wrapped", instret_o, exp_instret);

    // Unsupported opcode traps and stays in TRAP until reset.
    op_i = 7'b0110111;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      expect_state("trap_state", 4'd11);
      check("trap_illegal", {31'd0, illegal_o}, 32'd1);
      check("trap_enables", {27'd0, mem_req_o, mem_write_o, ir_write_o, pc_write_o,
            reg_write_o}, 32'd0);
      check("trap_instret", instret_o, exp_instret);
      step();
    end
    // imm_src depends only on the opcode, even in TRAP.
    for (int i = 0; i < 5; i++) begin
      op_i = imm_ops[i];
      #1;
      check("imm_src", {30'd0, imm_src_o}, {30'd0, imm_exp[i]});
    end
    rst_i = 1'b1;
    #1;
    check("trap_rst_illegal", {31'd0, illegal_o}, 32'd0);
    step();
    rst_i = 1'b0;
    #1;
    expect_state("trap_rst_state", 4'd0);

    // Reset during a MEMREAD wait aborts with no request in that cycle.
    op_i = 7'b0000011;
    mem_ready_i = 1'b1;
    step();
    step();
    mem_ready_i = 1'b0;
    step();
    expect_state("ab_s3", 4'd3);
    rst_i = 1'b1;
    #1;
    check("ab_req", {31'd0, mem_req_o}, 32'd0);
    step();
    rst_i = 1'b0;
    #1;
    expect_state("ab_state", 4'd0);
    check("ab_instret", instret_o, 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM for an area-reduced RV32I core variant that shares one ALU and one unified instruction/data memory port across all instruction phases. It reuses the pipeline decoder's control encodings for result_src, imm_src and alu_op, and the existing ALU decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and inserts memory wait-states via a ready handshake. It also keeps a retired-instruction counter and traps on unsupported opcodes.

## Interface
- No parameters.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- op_i  in  7  opcode field of the instruction register.
- funct3_i  in  3  funct3 field of the instruction register; only bit 0 is used (beq/bne).
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory access completes this cycle.
- mem_req_o  out  1  memory access request.
- mem_write_o  out  1  memory write strobe.
- adr_src_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write_o  out  1  load instruction register and OldPC.
- pc_write_o  out  1  PC register enable.
- reg_write_o  out  1  register file write enable.
- alu_src_a_o  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b_o  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alu_op_o  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded.
- result_src_o  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- imm_src_o  out  2  immediate type: I = 00, S = 01, B = 10, J = 11.
- state_o  out  4  current state encoding, for debug.
- illegal_o  out  1  high while in TRAP.
- instret_o  out  32  retired-instruction count.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11. Encodings 12-15 are unreachable and recover to FETCH.
- imm_src_o is a pure function of op_i in every state:
  - 0000011 or 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - otherwise 00
- Per-state outputs. Any output not listed is 0.
  - FETCH: mem_req = 1, adr_src = 0, a = 00, b = 10, alu_op = 00, result_src = 10. When mem_ready_i = 1: ir_write = 1 and pc_write = 1. Otherwise the FSM stays in FETCH.
  - DECODE: a = 01, b = 01, alu_op = 00. This computes the branch/jump target.
  - MEMADR: a = 10, b = 01, alu_op = 00.
  - MEMREAD: mem_req = 1, adr_src = 1. Stays until mem_ready_i = 1.
  - MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. Stays until mem_ready_i = 1.
  - MEMWB: result_src = 01, reg_write = 1.
  - EXECR: a = 10, b = 00, alu_op = 10.
  - EXECI: a = 10, b = 01, alu_op = 10.
  - ALUWB: result_src = 00, reg_write = 1.
  - BRANCH: a = 10, b = 00, alu_op = 01, result_src = 00, pc_write = zero_i XOR funct3_i[0].
  - JAL: a = 01, b = 10, alu_op = 00, result_src = 00, pc_write = 1.
  - TRAP: all enables are 0; illegal_o = 1.
- Transitions:
  - FETCH → DECODE when mem_ready_i = 1.
  - DECODE → MEMADR for load (0000011) or store (0100011).
  - DECODE → EXECR for 0110011; EXECI for 0010011; BRANCH for 1100011; JAL for 1101111.
  - DECODE → TRAP for any other opcode.
  - MEMADR → MEMREAD for a load, → MEMWRITE for a store, with op_i held.
  - MEMREAD → MEMWB when mem_ready_i = 1.
  - EXECR → ALUWB; EXECI → ALUWB; JAL → ALUWB.
  - MEMWB, ALUWB and BRANCH → FETCH.
  - MEMWRITE → FETCH when mem_ready_i = 1.
  - TRAP → TRAP until reset.
- instret_o increments by 1 on each retiring transition into FETCH: from MEMWB, ALUWB, BRANCH, or MEMWRITE with ready. It wraps from 0xFFFFFFFF to 0. TRAP does not count.

## Timing
- Reset: state = FETCH and instret_o = 0 on the first edge with rst_i = 1.
- While rst_i = 1: mem_req_o, mem_write_o, ir_write_o, pc_write_o and reg_write_o are forced to 0; illegal_o = 0.
- Reset mid-instruction, including during a memory wait or in TRAP, aborts on the next edge with no write issued that cycle.
- Control outputs are combinational from state. Exceptions: pc_write_o and ir_write_o in FETCH and BRANCH also depend on mem_ready_i, zero_i and funct3_i in the same cycle.
- Latency with zero wait-states (mem_ready_i = 1 whenever requested):
  - branch: 3 cycles
  - R-type, I-type ALU, store, JAL: 4 cycles
  - load: 5 cycles
- Each cycle of mem_ready_i = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle. mem_req_o, adr_src_o and mem_write_o are held stable throughout the wait.
- mem_ready_i is ignored outside memory states.

## Test plan
- Reset with rst_i = 1 for 2 cycles → state_o = 0, instret_o = 0, all enables 0. Release with mem_ready_i = 1 → ir_write_o = pc_write_o = 1 in the first cycle.
- R-type op_i = 0110011 with ready always 1 → state sequence 0, 1, 6, 8, 0 → reg_write_o = 1 only in state 8; instret_o = 1 after the fourth edge.
- Load op_i = 0000011 with mem_ready_i = 0 for 2 cycles in MEMREAD → sequence 0, 1, 2, 3, 3, 3, 4, 0; adr_src_o = 1 and mem_req_o = 1 held through all three MEMREAD cycles; result_src_o = 01 in state 4.
- Branch funct3 = 000: zero_i = 1 → pc_write_o = 1; zero_i = 0 → pc_write_o = 0. funct3 = 001 inverts this. Each branch retires in 3 cycles.
- Opcode 0110111 (unsupported) → DECODE → TRAP; illegal_o = 1 held for 10 cycles; instret_o unchanged. Asserting rst_i → state 0 and illegal_o = 0.
- Preload instret_o near wrap by retiring 2^32 - 1 instructions with a forced count, or via a bench-side force → next retirement yields 0. A store with mem_ready_i low for 3 cycles keeps mem_write_o = 1 for 4 cycles.
